fir_inverse4: RTL and testbench

- Exact inverse (deconvolution) of the team's 4-tap, 8-bit FIR with 3-bit coefficients.
- Consumes the filtered stream y[n] and reconstructs the original samples x[n] modulo 2^DW.
- Uses a sequential multiply-accumulate (one tap per cycle) with valid/ready handshakes on both sides.
- Sits on the receive side of the filter path for loopback checking and channel equalisation.

---
 rtl/fir_inverse4_pkg.sv | 23 ++
 rtl/fir_inverse4_hist.sv | 47 ++++
 rtl/fir_inverse4.sv | 110 +++++++++++
 tb/tb_fir_inverse4.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_inverse4_pkg.sv
// Shared constants, state codes and the odd-inverse helper for fir_inverse4.
package fir_inverse4_pkg;

   localparam int DW_DEF = 8;
   localparam int CW_DEF = 3;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] MAC   = 2'd1;
   localparam logic [1:0] SCALE = 2'd2;
   localparam logic [1:0] OUT   = 2'd3;

   // Each Newton step doubles the correct low bits; an odd b is already its own inverse mod 8.
   function automatic logic [31:0] odd_inverse(input logic [31:0] b, input int dw);
      logic [31:0] inv;
      int          iters;
      iters = $clog2((dw + 2) / 3);
      inv   = b;
      for (int i = 0; i < 5; i++)
         if (i < iters) inv = inv * (32'd2 - b * inv);
      return inv;
   endfunction

endpackage

// File: rtl/fir_inverse4_hist.sv
// Three-deep history of emitted samples with tap-select read of (h, B) pairs.
module fir_inverse4_hist
   import fir_inverse4_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          clr,
   input  logic          shift,
   input  logic [DW-1:0] din,
   input  logic [1:0]    k,
   input  logic [CW-1:0] b0,
   input  logic [CW-1:0] b1,
   input  logic [CW-1:0] b2,
   output logic [DW-1:0] h_tap,
   output logic [CW-1:0] b_tap
);

   logic [DW-1:0] h1, h2, h3;

   always_ff @(posedge CLK) begin
      if (reset || clr) begin
         h1 <= '0;
         h2 <= '0;
         h3 <= '0;
      end else if (shift) begin
         h3 <= h2;
         h2 <= h1;
         h1 <= din;
      end
   end

   // k walks newest-to-oldest history, pairing each with its own coefficient.
   always_comb begin
      h_tap = h1;
      b_tap = b2;
      case (k)
         2'd0:    begin h_tap = h1; b_tap = b2; end
         2'd1:    begin h_tap = h2; b_tap = b1; end
         2'd2:    begin h_tap = h3; b_tap = b0; end
         default: begin h_tap = '0; b_tap = '0; end
      endcase
   end

endmodule

// File: rtl/fir_inverse4.sv
// Sequential deconvolver for the 4-tap FIR: x[n] = inv(B3)*(y[n] - sum Bk*h).
// Optional macro FIRINV_FLUSH_EN adds a flush port that clears history from IDLE.
module fir_inverse4
   import fir_inverse4_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic [DW-1:0] Yin,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] B0,
   input  logic [CW-1:0] B1,
   input  logic [CW-1:0] B2,
   input  logic [CW-1:0] B3,
`ifdef FIRINV_FLUSH_EN
   input  logic          flush,
`endif
   output logic [DW-1:0] Xout,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          coef_err
);

   logic [1:0]    state;
   logic [DW-1:0] acc;
   logic [CW-1:0] b0_q, b1_q, b2_q, b3_q;
   logic [1:0]    k;
   logic [DW-1:0] h_tap;
   logic [CW-1:0] b_tap;
   logic [DW-1:0] inv;
   logic          hist_clr;
   logic          accept;

`ifdef FIRINV_FLUSH_EN
   assign hist_clr = flush && (state == IDLE);
`else
   assign hist_clr = 1'b0;
`endif

   // Flush wins over accept in IDLE.
   assign in_ready  = (state == IDLE) && !hist_clr;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == OUT);
   assign inv       = DW'(odd_inverse(32'(b3_q), DW));

   always_ff @(posedge CLK) begin
      if (reset) begin
         state    <= IDLE;
         acc      <= '0;
         b0_q     <= '0;
         b1_q     <= '0;
         b2_q     <= '0;
         b3_q     <= '0;
         k        <= '0;
         Xout     <= '0;
         coef_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc   <= Yin;
                  b0_q  <= B0;
                  b1_q  <= B1;
                  b2_q  <= B2;
                  b3_q  <= B3;
                  k     <= 2'd0;
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc - DW'(b_tap) * h_tap;
               k   <= k + 2'd1;
               if (k == 2'd2) state <= SCALE;
            end
            SCALE: begin
               // An even B3 has no inverse; emit 0 so history stays well defined.
               if (!b3_q[0]) begin
                  Xout     <= '0;
                  coef_err <= 1'b1;
               end else begin
                  Xout <= acc * inv;
               end
               state <= OUT;
            end
            OUT: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   fir_inverse4_hist #(.DW(DW), .CW(CW)) u_hist (
      .CLK   (CLK),
      .reset (reset),
      .clr   (hist_clr),
      .shift ((state == OUT) && out_ready),
      .din   (Xout),
      .k     (k),
      .b0    (b0_q),
      .b1    (b1_q),
      .b2    (b2_q),
      .h_tap (h_tap),
      .b_tap (b_tap)
   );

endmodule

// File: tb/tb_fir_inverse4.sv
// Self-checking bench for fir_inverse4: vector table, forward-filter model, corner sequences.
module tb_fir_inverse4;

   logic       CLK = 1'b0;
   logic       reset;
   logic [7:0] Yin;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] B0, B1, B2, B3;
   logic [7:0] Xout;
   logic       out_valid;
   logic       out_ready;
   logic       coef_err;
`ifdef FIRINV_FLUSH_EN
   logic       flush = 1'b0;
`endif

   int ntests = 0;
   int nfail  = 0;

   always #5 CLK = ~CLK;

   fir_inverse4 dut (
      .CLK       (CLK),
      .reset     (reset),
      .Yin       (Yin),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .B0        (B0),
      .B1        (B1),
      .B2        (B2),
      .B3        (B3),
`ifdef FIRINV_FLUSH_EN
      .flush     (flush),
`endif
      .Xout      (Xout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .coef_err  (coef_err)
   );

   typedef struct {
      bit         rst;
      logic [2:0] b0, b1, b2, b3;
      logic [7:0] y;
      logic [7:0] x;
   } vec_t;

   vec_t tv[10];

   task automatic chk(input string name, input int act, input int exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      reset = 1'b1;
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      reset = 1'b0;
   endtask

   // Offers one sample, waits for its output, and completes the handshake if out_ready is high.
   task automatic do_sample(input logic [7:0] y, input logic [2:0] b0, b1, b2, b3,
                            output logic [7:0] x, output int lat);
      int g = 0;
      @(negedge CLK);
      while (!in_ready && g < 50) begin
         @(negedge CLK);
         g++;
      end
      if (g >= 50) chk("in_ready_timeout", 0, 1);
      Yin = y; B0 = b0; B1 = b1; B2 = b2; B3 = b3;
      in_valid = 1'b1;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      B0 = 3'($urandom); B1 = 3'($urandom); B2 = 3'($urandom); B3 = 3'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge CLK);
         #1;
         lat++;
      end
      x = Xout;
      if (out_ready) begin
         @(posedge CLK);
         #1;
      end
   endtask

   logic [7:0] x, hx1, hx2, hx3, xr, yr, x0;
   logic [2:0] rb0, rb1, rb2, rb3;
   int         lat;
   bit         ov_seen;

   initial begin
      reset = 1'b1; Yin = '0; in_valid = 1'b0; out_ready = 1'b1;
      B0 = '0; B1 = '0; B2 = '0; B3 = 3'd1;

      tv[0] = '{1, 0, 0, 0, 1, 8'h5A, 8'h5A};
      tv[1] = '{0, 0, 0, 0, 1, 8'h00, 8'h00};
      tv[2] = '{0, 0, 0, 0, 1, 8'hFF, 8'hFF};
      tv[3] = '{0, 0, 0, 0, 3, 8'h03, 8'h01};
      tv[4] = '{0, 0, 0, 0, 3, 8'h01, 8'hAB};
      tv[5] = '{0, 0, 0, 0, 7, 8'h07, 8'h01};
      tv[6] = '{0, 0, 0, 0, 5, 8'h05, 8'h01};
      tv[7] = '{1, 0, 0, 1, 1, 8'd5,  8'd5};
      tv[8] = '{0, 0, 0, 1, 1, 8'd7,  8'd2};
      tv[9] = '{0, 0, 0, 1, 1, 8'd10, 8'd8};

      do_reset();
      chk("reset_xout", int'(Xout), 0);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_coef_err", int'(coef_err), 0);

      for (int i = 0; i < 10; i++) begin
         if (tv[i].rst) do_reset();
         do_sample(tv[i].y, tv[i].b0, tv[i].b1, tv[i].b2, tv[i].b3, x, lat);
         chk($sformatf("vec%0d_xout", i), int'(x), int'(tv[i].x));
         chk($sformatf("vec%0d_latency", i), lat, 4);
      end

      // Random stream through the forward filter; the block must recover x exactly.
      do_reset();
      hx1 = 0; hx2 = 0; hx3 = 0;
      for (int i = 0; i < 1000; i++) begin
         xr  = 8'($urandom);
         rb0 = 3'($urandom); rb1 = 3'($urandom); rb2 = 3'($urandom);
         rb3 = {2'($urandom), 1'b1};
         yr  = 8'(rb3 * xr + rb2 * hx1 + rb1 * hx2 + rb0 * hx3);
         do_sample(yr, rb0, rb1, rb2, rb3, x, lat);
         chk($sformatf("rand%0d", i), int'(x), int'(xr));
         hx3 = hx2; hx2 = hx1; hx1 = xr;
      end

      // Backpressure: output held, second sample waits for the output handshake.
      out_ready = 1'b0;
      do_sample(8'h3C, 0, 0, 0, 1, x0, lat);
      chk("bp_latency", lat, 4);
      @(negedge CLK);
      Yin = 8'h33; B0 = 0; B1 = 0; B2 = 0; B3 = 1; in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge CLK);
         #1;
         chk($sformatf("bp_xout%0d", c), int'(Xout), 8'h3C);
         chk($sformatf("bp_valid%0d", c), int'(out_valid), 1);
         chk($sformatf("bp_in_ready%0d", c), int'(in_ready), 0);
      end
      @(negedge CLK);
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      chk("bp_idle_after_hs", int'(in_ready), 1);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      chk("bp_accepted", int'(in_ready), 0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge CLK);
         #1;
         lat++;
      end
      chk("bp_second_latency", lat, 4);
      chk("bp_second_xout", int'(Xout), 8'h33);
      @(posedge CLK);
      #1;

      // Even B3 sets a sticky error and emits zero.
      do_sample(8'h10, 0, 0, 0, 2, x, lat);
      chk("even_xout", int'(x), 0);
      chk("even_coef_err", int'(coef_err), 1);
      do_sample(8'h21, 0, 0, 0, 1, x, lat);
      chk("after_even_xout", int'(x), 8'h21);
      chk("after_even_coef_err", int'(coef_err), 1);
      do_sample(8'h44, 0, 0, 0, 1, x, lat);

      // Reset mid-MAC drops the sample and clears history and the error flag.
      @(negedge CLK);
      Yin = 8'h77; B0 = 0; B1 = 0; B2 = 0; B3 = 1; in_valid = 1'b1;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      chk("midmac_busy", int'(in_ready), 0);
      @(negedge CLK);
      reset = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      reset = 1'b0;
      ov_seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge CLK);
         #1;
         if (out_valid) ov_seen = 1;
      end
      chk("midmac_no_output", int'(ov_seen), 0);
      chk("midmac_coef_err", int'(coef_err), 0);
      chk("midmac_in_ready", int'(in_ready), 1);
      do_sample(8'h09, 1, 1, 1, 1, x, lat);
      chk("post_reset_hist_zero", int'(x), 8'h09);
      do_sample(8'h09, 0, 0, 0, 1, x, lat);
      chk("post_reset_identity", int'(x), 8'h09);

`ifdef FIRINV_FLUSH_EN
      // History is now 9,9,0; flush must zero it before the next sample.
      @(negedge CLK);
      flush = 1'b1;
      Yin = 8'h55; in_valid = 1'b1;
      #1;
      chk("flush_blocks_accept", int'(in_ready), 0);
      @(posedge CLK);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_no_accept", int'(in_ready), 1);
      do_sample(8'd4, 0, 0, 1, 1, x, lat);
      chk("flush_result", int'(x), 4);
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
